// File: rtl/cbfp1_ctrl.sv
// -----------------------------------------------------------------------------
// cbfp1_ctrl
//
// Purpose
//   Block exponent controller for a conditional block floating point (CBFP)
//   stage. Complex samples are written into one bank of a two-bank ping-pong
//   buffer while the minimum leading-sign-bit count ("lead") over both
//   components of the block is tracked. When a block's last sample is
//   accepted, that minimum becomes the block exponent and the bank is drained
//   in index order, one sample per cycle, to the downstream shifters.
//
// Parameters
//   INPUT_WIDTH  signed width of each real/imag component (default 25)
//   SHIFT_WIDTH  width of shift_value (default 5)
//   BLOCK_LEN    complex samples per block, power of two >= 2 (default 16)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     input sample strobe, no backpressure
//   din_re/im    input sample components
//   out_valid    output sample strobe, BLOCK_LEN contiguous cycles per block
//   dout_re/im   buffered unshifted sample, held while out_valid is low
//   shift_value  block exponent, constant across a block's drain
//   blk_last     high with the final out_valid sample of a block
//   blk_count    (CBFP1_STATS_EN only) wrapping 16-bit count of blk_last
//
// Handshake: in_valid qualifies din_* on the same rising edge; there is no
// ready. out_valid qualifies dout_*, shift_value and blk_last on the same
// cycle; the consumer must take every out_valid sample.
//
// Configuration macro: CBFP1_STATS_EN adds the blk_count output and counter.
// -----------------------------------------------------------------------------
module cbfp1_ctrl #(
    parameter int INPUT_WIDTH = 25,
    parameter int SHIFT_WIDTH = 5,
    parameter int BLOCK_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [INPUT_WIDTH-1:0] din_re,
    input  logic [INPUT_WIDTH-1:0] din_im,
    output logic                   out_valid,
    output logic [INPUT_WIDTH-1:0] dout_re,
    output logic [INPUT_WIDTH-1:0] dout_im,
    output logic [SHIFT_WIDTH-1:0] shift_value,
    output logic                   blk_last
`ifdef CBFP1_STATS_EN
    ,
    output logic [15:0]            blk_count
`endif
);

    localparam int IDX_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(BLOCK_LEN - 1);
    localparam logic [SHIFT_WIDTH-1:0] MAX_LEAD = SHIFT_WIDTH'(INPUT_WIDTH - 1);

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

    // Number of bits below the sign bit that equal the sign bit.
    function automatic logic [SHIFT_WIDTH-1:0] lead(input logic [INPUT_WIDTH-1:0] x);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = INPUT_WIDTH - 2; i >= 0; i--) begin
            if (run && (x[i] == x[INPUT_WIDTH-1])) begin
                n = n + 1;
            end else begin
                run = 1'b0;
            end
        end
        return SHIFT_WIDTH'(n);
    endfunction

    function automatic logic [SHIFT_WIDTH-1:0] min2(input logic [SHIFT_WIDTH-1:0] a,
                                                    input logic [SHIFT_WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Ping-pong storage, address = {bank, index}. Contents are not reset.
    logic [INPUT_WIDTH-1:0] mem_re [0:2*BLOCK_LEN-1];
    logic [INPUT_WIDTH-1:0] mem_im [0:2*BLOCK_LEN-1];

    // Write side
    logic [IDX_W-1:0]       wr_idx;
    logic                   wr_bank;
    logic [SHIFT_WIDTH-1:0] blk_min;
    logic [SHIFT_WIDTH-1:0] pend_shift;
    logic [SHIFT_WIDTH-1:0] cand_lead;
    logic [SHIFT_WIDTH-1:0] blk_min_next;
    logic                   drain_start;

    // Read side
    rd_state_t        rd_state, rd_state_n;
    logic [IDX_W-1:0] rd_idx, rd_idx_n;
    logic             rd_bank, rd_bank_n;
    logic             emit;
    logic             emit_last;

    // -------------------------------------------------------------------------
    // Write side: store, track the block minimum, hand the block to the reader
    // -------------------------------------------------------------------------
    always_comb begin
        cand_lead    = min2(lead(din_re), lead(din_im));
        // Sample 0 of a block never inherits the previous block's minimum.
        blk_min_next = (wr_idx == '0) ? cand_lead : min2(blk_min, cand_lead);
        drain_start  = in_valid && (wr_idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem_re[{wr_bank, wr_idx}] <= din_re;
            mem_im[{wr_bank, wr_idx}] <= din_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx     <= '0;
            wr_bank    <= 1'b0;
            blk_min    <= MAX_LEAD;
            pend_shift <= '0;
        end else if (in_valid) begin
            wr_idx <= wr_idx + IDX_W'(1);
            if (wr_idx == LAST_IDX) begin
                wr_bank    <= ~wr_bank;
                // Held here until the first output of the drain so that the
                // tail of a back-to-back previous drain keeps its exponent.
                pend_shift <= blk_min_next;
                blk_min    <= MAX_LEAD;
            end else begin
                blk_min <= blk_min_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_idx   <= '0;
            rd_bank  <= 1'b0;
        end else begin
            rd_state <= rd_state_n;
            rd_idx   <= rd_idx_n;
            rd_bank  <= rd_bank_n;
        end
    end

    always_comb begin
        rd_state_n = rd_state;
        rd_idx_n   = rd_idx;
        rd_bank_n  = rd_bank;
        emit       = 1'b0;
        emit_last  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (drain_start) begin
                    rd_state_n = R_DRAIN;
                    rd_idx_n   = '0;
                    rd_bank_n  = wr_bank;
                end
            end
            R_DRAIN: begin
                emit     = 1'b1;
                rd_idx_n = rd_idx + IDX_W'(1);
                if (rd_idx == LAST_IDX) begin
                    emit_last = 1'b1;
                    if (drain_start) begin
                        // Back-to-back: the next block's drain follows directly.
                        rd_idx_n  = '0;
                        rd_bank_n = wr_bank;
                    end else begin
                        rd_state_n = R_IDLE;
                    end
                end
            end
            default: begin
                rd_state_n = R_IDLE;
            end
        endcase
    end

    // Registered outputs: one cycle after the FSM enters R_DRAIN the first
    // sample appears, i.e. one edge after the last input was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            blk_last    <= 1'b0;
            dout_re     <= '0;
            dout_im     <= '0;
            shift_value <= '0;
        end else begin
            out_valid <= emit;
            blk_last  <= emit_last;
            if (emit) begin
                dout_re <= mem_re[{rd_bank, rd_idx}];
                dout_im <= mem_im[{rd_bank, rd_idx}];
                if (rd_idx == '0) begin
                    shift_value <= pend_shift;
                end
            end
        end
    end

`ifdef CBFP1_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count <= '0;
        end else if (emit_last) begin
            blk_count <= blk_count + 16'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // Input rate is at most one sample per cycle, so a drain must always have
    // finished (or be on its final index) when the next one starts.
    always_ff @(posedge clk) begin
        if (!rst && drain_start) begin
            assert (rd_state == R_IDLE || rd_idx == LAST_IDX)
            else $error("cbfp1_ctrl: drain start while a drain is in progress");
        end
    end
`endif

endmodule
